// File: rtl/cipher_seq_ctrl_if.sv
// Plaintext input stream and readout output stream of the cipher sequencing controller.
// master = upstream/downstream side, slave = the controller.
interface cipher_seq_ctrl_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       in_ready;
   logic       mode;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_ready;

   modport master (
      output in_valid, in_data, in_last, mode, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, mode, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/cipher_seq_ctrl.sv
// Sequencer for the 8-byte chained-XOR cipher core: loads plaintext bytes into the core,
// then walks the byte select to stream the stored message back out and clears the core.
module cipher_seq_ctrl #(
   parameter int DEPTH  = 8,
   parameter int SETTLE = 1,
   localparam int SEL_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   cipher_seq_ctrl_if.slave strm,
   output logic [7:0]       core_data,
   output logic             core_encrypt,
   output logic             core_inc,
   output logic             core_view,
   output logic [SEL_W-1:0] core_sel,
   output logic             core_rst_n,
   input  logic [7:0]       core_rdata,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             overflow
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PULSE    = 3'd1,
      GAP      = 3'd2,
      SEL      = 3'd3,
      SETTLE_W = 3'd4,
      EMIT     = 3'd5,
      CLEAR    = 3'd6
   } state_t;

   localparam logic [1:0] SETTLE_LOAD = 2'(SETTLE - 1);

   state_t           state_reg, state_next;
   logic             in_ready_reg, in_ready_next;
   logic             out_valid_reg, out_valid_next;
   logic [7:0]       out_data_reg, out_data_next;
   logic             out_last_reg, out_last_next;
   logic [7:0]       core_data_reg, core_data_next;
   logic             core_encrypt_reg, core_encrypt_next;
   logic             core_inc_reg, core_inc_next;
   logic             core_view_reg, core_view_next;
   logic [SEL_W-1:0] core_sel_reg, core_sel_next;
   logic             core_rst_n_reg, core_rst_n_next;
   logic             busy_reg, busy_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic             overflow_reg, overflow_next;
   logic             last_q_reg, last_q_next;
   logic             view_q_reg, view_q_next;
   logic [1:0]       settle_cnt_reg, settle_cnt_next;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         in_ready_reg     <= 1'b0;
         out_valid_reg    <= 1'b0;
         out_data_reg     <= 8'h00;
         out_last_reg     <= 1'b0;
         core_data_reg    <= 8'h00;
         core_encrypt_reg <= 1'b0;
         core_inc_reg     <= 1'b0;
         core_view_reg    <= 1'b0;
         core_sel_reg     <= '0;
         core_rst_n_reg   <= 1'b0;
         busy_reg         <= 1'b0;
         count_reg        <= '0;
         overflow_reg     <= 1'b0;
         last_q_reg       <= 1'b0;
         view_q_reg       <= 1'b0;
         settle_cnt_reg   <= 2'd0;
      end else begin
         state_reg        <= state_next;
         in_ready_reg     <= in_ready_next;
         out_valid_reg    <= out_valid_next;
         out_data_reg     <= out_data_next;
         out_last_reg     <= out_last_next;
         core_data_reg    <= core_data_next;
         core_encrypt_reg <= core_encrypt_next;
         core_inc_reg     <= core_inc_next;
         core_view_reg    <= core_view_next;
         core_sel_reg     <= core_sel_next;
         core_rst_n_reg   <= core_rst_n_next;
         busy_reg         <= busy_next;
         count_reg        <= count_next;
         overflow_reg     <= overflow_next;
         last_q_reg       <= last_q_next;
         view_q_reg       <= view_q_next;
         settle_cnt_reg   <= settle_cnt_next;
      end
   end

   // Every output is computed one cycle ahead so that it is registered in the state it belongs to.
   always_comb begin
      state_next        = state_reg;
      in_ready_next     = in_ready_reg;
      out_valid_next    = out_valid_reg;
      out_data_next     = out_data_reg;
      out_last_next     = out_last_reg;
      core_data_next    = core_data_reg;
      core_encrypt_next = core_encrypt_reg;
      core_inc_next     = core_inc_reg;
      core_view_next    = core_view_reg;
      core_sel_next     = core_sel_reg;
      core_rst_n_next   = core_rst_n_reg;
      count_next        = count_reg;
      overflow_next     = overflow_reg;
      last_q_next       = last_q_reg;
      view_q_next       = view_q_reg;
      settle_cnt_next   = settle_cnt_reg;

      case (state_reg)
         IDLE: begin
            in_ready_next   = 1'b1;
            core_rst_n_next = 1'b1;
            if (strm.in_valid && in_ready_reg) begin
               core_data_next    = strm.in_data;
               core_encrypt_next = 1'b1;
               core_inc_next     = 1'b1;
               last_q_next       = strm.in_last;
               if (strm.in_last) begin
                  view_q_next = strm.mode;
               end
               // An empty core means this is the first byte of a new message.
               if (count_reg == '0) begin
                  overflow_next = 1'b0;
               end
               in_ready_next = 1'b0;
               state_next    = PULSE;
            end
         end
         PULSE: begin
            core_inc_next = 1'b0;
            if (count_reg == CNT_W'(DEPTH)) begin
               overflow_next = 1'b1;
            end else begin
               count_next = count_reg + CNT_W'(1);
            end
            state_next = GAP;
         end
         GAP: begin
            if (last_q_reg) begin
               core_encrypt_next = 1'b0;
               core_view_next    = view_q_reg;
               core_sel_next     = SEL_W'(count_reg - CNT_W'(1));
               state_next        = SEL;
            end else begin
               in_ready_next = 1'b1;
               state_next    = IDLE;
            end
         end
         SEL: begin
            settle_cnt_next = SETTLE_LOAD;
            state_next      = SETTLE_W;
         end
         SETTLE_W: begin
            if (settle_cnt_reg == 2'd0) begin
               out_data_next  = core_rdata;
               out_valid_next = 1'b1;
               out_last_next  = (core_sel_reg == '0);
               state_next     = EMIT;
            end else begin
               settle_cnt_next = settle_cnt_reg - 2'd1;
            end
         end
         EMIT: begin
            if (strm.out_ready) begin
               out_valid_next = 1'b0;
               out_last_next  = 1'b0;
               if (core_sel_reg == '0) begin
                  core_rst_n_next = 1'b0;
                  count_next      = '0;
                  state_next      = CLEAR;
               end else begin
                  core_sel_next   = core_sel_reg - SEL_W'(1);
                  settle_cnt_next = SETTLE_LOAD;
                  state_next      = SETTLE_W;
               end
            end
         end
         CLEAR: begin
            core_rst_n_next = 1'b1;
            in_ready_next   = 1'b1;
            state_next      = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      busy_next = (state_next != IDLE);
   end

   assign strm.in_ready  = in_ready_reg;
   assign strm.out_valid = out_valid_reg;
   assign strm.out_data  = out_data_reg;
   assign strm.out_last  = out_last_reg;
   assign core_data      = core_data_reg;
   assign core_encrypt   = core_encrypt_reg;
   assign core_inc       = core_inc_reg;
   assign core_view      = core_view_reg;
   assign core_sel       = core_sel_reg;
   assign core_rst_n     = core_rst_n_reg;
   assign busy           = busy_reg;
   assign count          = count_reg;
   assign overflow       = overflow_reg;

endmodule

// File: tb/tb_cipher_seq_ctrl.sv
// Bench for cipher_seq_ctrl: a behavioural cipher core feeds core_rdata, and readout bytes
// are checked against values computed directly from the plaintext and mode.
module tb_cipher_seq_ctrl;
   localparam int DEPTH  = 8;
   localparam int SETTLE = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] core_data;
   logic       core_encrypt, core_inc, core_view, core_rst_n;
   logic [2:0] core_sel;
   logic [7:0] core_rdata;
   logic       busy, overflow;
   logic [3:0] count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cipher_seq_ctrl_if strm();

   cipher_seq_ctrl #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
      .clk          (clk),
      .rst          (rst),
      .strm         (strm),
      .core_data    (core_data),
      .core_encrypt (core_encrypt),
      .core_inc     (core_inc),
      .core_view    (core_view),
      .core_sel     (core_sel),
      .core_rst_n   (core_rst_n),
      .core_rdata   (core_rdata),
      .busy         (busy),
      .count        (count),
      .overflow     (overflow)
   );

   // Behavioural core: loads on the rising edge of core_inc, newest byte at index 0.
   logic [7:0] cm_plain  [DEPTH];
   logic [7:0] cm_cipher [DEPTH];
   logic [7:0] cm_chain = 8'h00;
   logic       cm_inc_q = 1'b0;

   always @(posedge clk) begin
      cm_inc_q <= core_inc;
      if (core_rst_n !== 1'b1) begin
         cm_chain <= 8'h00;
         for (int i = 0; i < DEPTH; i++) begin
            cm_plain[i]  <= 8'h00;
            cm_cipher[i] <= 8'h00;
         end
      end else if (core_inc && !cm_inc_q && core_encrypt) begin
         for (int i = DEPTH - 1; i > 0; i--) begin
            cm_plain[i]  <= cm_plain[i-1];
            cm_cipher[i] <= cm_cipher[i-1];
         end
         cm_plain[0]  <= core_data;
         cm_cipher[0] <= cm_chain ^ core_data;
         cm_chain     <= cm_chain ^ core_data;
      end
   end

   assign core_rdata = core_view ? cm_cipher[core_sel] : cm_plain[core_sel];

   logic [7:0] msg   [$];
   logic [7:0] exp_q [$];
   int         msg_no = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference: the last DEPTH bytes in input order; encrypted view is the running XOR from the message start.
   task automatic build_expected(input bit md);
      int         len;
      int         n;
      int         j;
      logic [7:0] acc;
      exp_q.delete();
      len = msg.size();
      n   = imin(len, DEPTH);
      for (int k = 0; k < n; k++) begin
         j   = len - n + k;
         acc = 8'h00;
         for (int t = 0; t <= j; t++) acc = acc ^ msg[t];
         exp_q.push_back(md ? acc : msg[j]);
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_in_ready",   32'(strm.in_ready),  32'd0);
      chk("rst_out_valid",  32'(strm.out_valid), 32'd0);
      chk("rst_out_data",   32'(strm.out_data),  32'd0);
      chk("rst_out_last",   32'(strm.out_last),  32'd0);
      chk("rst_core_data",  32'(core_data),      32'd0);
      chk("rst_core_enc",   32'(core_encrypt),   32'd0);
      chk("rst_core_inc",   32'(core_inc),       32'd0);
      chk("rst_core_view",  32'(core_view),      32'd0);
      chk("rst_core_sel",   32'(core_sel),       32'd0);
      chk("rst_core_rst_n", 32'(core_rst_n),     32'd0);
      chk("rst_busy",       32'(busy),           32'd0);
      chk("rst_count",      32'(count),          32'd0);
      chk("rst_overflow",   32'(overflow),       32'd0);
   endtask

   // Returns right after the posedge that takes the final (in_last) byte.
   task automatic send_msg(input bit md);
      int  w;
      int  sent;
      int  gap;
      bit  last;
      sent = 0;
      gap  = 1;
      @(negedge clk);
      for (int i = 0; i < msg.size(); i++) begin
         last           = (i == msg.size() - 1);
         strm.in_valid  = 1'b1;
         strm.in_data   = msg[i];
         strm.in_last   = last;
         strm.mode      = last ? md : 1'($urandom);
         w = 0;
         while (!strm.in_ready && w < 20) begin
            @(negedge clk);
            w++;
         end
         chk("in_ready_wait", 32'(strm.in_ready), 32'd1);
         if (i > 0 && gap == 0) chk("load_throughput", 32'(w), 32'd1);
         @(posedge clk);
         sent++;
         if (!last) begin
            @(negedge clk);
            strm.in_valid = 1'b0;
            strm.in_data  = 8'($urandom);
            strm.mode     = 1'($urandom);
            chk("pulse_core_inc",  32'(core_inc),      32'd1);
            chk("pulse_in_ready",  32'(strm.in_ready), 32'd0);
            chk("pulse_core_data", 32'(core_data),     32'(msg[i]));
            @(negedge clk);
            chk("gap_core_inc", 32'(core_inc), 32'd0);
            chk("gap_count",    32'(count),    32'(imin(sent, DEPTH)));
            chk("gap_overflow", 32'(overflow), 32'(sent > DEPTH));
            gap = $urandom_range(0, 2);
            repeat (gap) @(negedge clk);
         end
      end
   endtask

   task automatic read_msg(input int stall);
      int n;
      int k_wait;
      int len;
      n   = exp_q.size();
      len = msg.size();
      strm.out_ready = (stall == 0);
      @(negedge clk);
      strm.in_valid = 1'b0;
      strm.in_last  = 1'b0;
      for (int k = 0; k < n; k++) begin
         k_wait = 0;
         while (!strm.out_valid && k_wait < 40) begin
            @(negedge clk);
            k_wait++;
         end
         chk("out_valid_rise", 32'(strm.out_valid), 32'd1);
         if (k == 0) begin
            chk("first_latency",  32'(k_wait),   32'(3 + SETTLE));
            chk("readout_count",  32'(count),    32'(n));
            chk("readout_ovf",    32'(overflow), 32'(len > DEPTH));
         end else begin
            chk("readout_gap", 32'(k_wait), 32'(SETTLE));
         end
         chk("out_data",         32'(strm.out_data), 32'(exp_q[k]));
         chk("out_last",         32'(strm.out_last), 32'(k == n - 1));
         chk("readout_in_ready", 32'(strm.in_ready), 32'd0);
         chk("readout_busy",     32'(busy),          32'd1);
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_valid", 32'(strm.out_valid), 32'd1);
            chk("hold_data",  32'(strm.out_data),  32'(exp_q[k]));
            chk("hold_last",  32'(strm.out_last),  32'(k == n - 1));
         end
         strm.out_ready = 1'b1;
         @(posedge clk);
         @(negedge clk);
         if (stall > 0) strm.out_ready = 1'b0;
         chk("after_hs_valid", 32'(strm.out_valid), 32'd0);
      end
      chk("clear_core_rst_n", 32'(core_rst_n),     32'd0);
      chk("clear_count",      32'(count),          32'd0);
      chk("clear_in_ready",   32'(strm.in_ready),  32'd0);
      @(negedge clk);
      chk("idle_core_rst_n", 32'(core_rst_n),     32'd1);
      chk("idle_in_ready",   32'(strm.in_ready),  32'd1);
      chk("idle_busy",       32'(busy),           32'd0);
      chk("idle_overflow",   32'(overflow),       32'(len > DEPTH));
      chk("idle_no_extra",   32'(strm.out_valid), 32'd0);
   endtask

   task automatic run_msg(input bit md, input int stall);
      $display("msg %0d: len=%0d mode=%0d stall=%0d", msg_no, msg.size(), md, stall);
      msg_no++;
      build_expected(md);
      send_msg(md);
      read_msg(stall);
   endtask

   initial begin
      int len;
      rst            = 1'b1;
      strm.in_valid  = 1'b0;
      strm.in_data   = 8'h00;
      strm.in_last   = 1'b0;
      strm.mode      = 1'b0;
      strm.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_in_ready", 32'(strm.in_ready), 32'd1);
      chk("post_rst_core_rst_n", 32'(core_rst_n), 32'd1);

      // Reset asserted while the first byte is in PULSE.
      strm.in_valid = 1'b1;
      strm.in_data  = 8'h5A;
      strm.in_last  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_core_inc", 32'(core_inc), 32'd1);
      rst           = 1'b1;
      strm.in_valid = 1'b0;
      @(negedge clk);
      check_reset_vals();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("reset during PULSE applied");

      msg = '{8'h41, 8'h42, 8'h43};
      run_msg(1'b1, 0);
      msg = '{8'h41, 8'h42, 8'h43};
      run_msg(1'b0, 0);

      msg.delete();
      for (int i = 1; i <= 10; i++) msg.push_back(8'(i));
      run_msg(1'b0, 0);

      msg.delete();
      for (int i = 0; i < 4; i++) msg.push_back(8'($urandom));
      run_msg(1'($urandom), 5);

      msg = '{8'hFF};
      run_msg(1'b1, 0);

      for (int m = 0; m < 6; m++) begin
         msg.delete();
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
         run_msg(1'($urandom), $urandom_range(0, 3));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
